// File: rtl/bep_pkg.sv
// bep_pkg: shared definitions for the biphase-mark (BEP) encode/decode path.
//   - default word width and half-bit length, shared with the decode side
//   - encoder FSM state type
// Optional feature macro: BEP_PARITY_EN adds the PARITY state (even parity
// bit appended after the MSB).
package bep_pkg;

    localparam int unsigned BEP_DATA_WIDTH_DEF      = 8;
    localparam int unsigned BEP_HALF_BIT_CYCLES_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND
`ifdef BEP_PARITY_EN
        , PARITY
`endif
    } bep_state_e;

endpackage

// File: rtl/bep_half_bit_timer.sv
// bep_half_bit_timer: half-bit period counter for the BEP encoder.
// Ports:
//   clock, reset_n  - rising-edge clock, synchronous active-low reset
//   restart         - clears the count and phase (word accepted this edge)
//   run             - count while high; held at zero otherwise
//   half_tick       - high in the last cycle of each half bit
//   phase           - 0 during the first half of a bit, 1 during the second
module bep_half_bit_timer
    import bep_pkg::*;
#(
    parameter int unsigned HALF_BIT_CYCLES = BEP_HALF_BIT_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic restart,
    input  logic run,
    output logic half_tick,
    output logic phase
);

    localparam int unsigned   CW       = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF_BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    assign half_tick = run && (cnt_q == CNT_LAST);
    assign phase     = phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart || !run) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/bep_encode.sv
// bep_encode: biphase-mark line encoder. Words taken over valid/ready are
// sent LSB first; the line toggles at every bit boundary and again mid-bit
// for each 1. The line holds its level when idle.
// Ports:
//   clock, reset_n - rising-edge clock, synchronous active-low reset
//   data_in        - word to send, sampled only on an accept edge
//   data_valid     - data_in is valid
//   data_ready     - encoder takes a word this cycle
//   line_out       - encoded line (registered)
//   busy           - frame in progress
// Optional feature macro: BEP_PARITY_EN appends an even-parity bit.
module bep_encode
    import bep_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = BEP_DATA_WIDTH_DEF,
    parameter int unsigned HALF_BIT_CYCLES = BEP_HALF_BIT_CYCLES_DEF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  line_out,
    output logic                  busy
);

    localparam int unsigned   BW       = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    bep_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  line_q, line_d;
    logic                  busy_q, busy_d;
    logic                  idle_q, idle_d;
`ifdef BEP_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic half_tick, phase;
    logic accept, last_bit, cur_bit, final_cycle;

    bep_half_bit_timer #(
        .HALF_BIT_CYCLES(HALF_BIT_CYCLES)
    ) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .restart  (accept),
        .run      (busy_q),
        .half_tick(half_tick),
        .phase    (phase)
    );

`ifdef BEP_PARITY_EN
    assign last_bit = (state_q == PARITY);
    assign cur_bit  = (state_q == PARITY) ? parity_q : shift_q[0];
`else
    assign last_bit = (state_q == SEND) && (bit_cnt_q == BIT_LAST);
    assign cur_bit  = shift_q[0];
`endif

    // Final cycle of the frame's last half bit: ready here allows a gapless
    // back-to-back accept. idle_q keeps ready low while in reset.
    assign final_cycle = busy_q && half_tick && phase && last_bit;
    assign data_ready  = idle_q || final_cycle;
    assign accept      = data_valid && data_ready;

    assign line_out = line_q;
    assign busy     = busy_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        line_d    = line_q;
        busy_d    = busy_q;
`ifdef BEP_PARITY_EN
        parity_d  = parity_q;
`endif
        if (accept) begin
            // The accept edge itself carries the bit-0 boundary toggle.
            state_d   = SEND;
            shift_d   = data_in;
            bit_cnt_d = '0;
            line_d    = ~line_q;
            busy_d    = 1'b1;
`ifdef BEP_PARITY_EN
            parity_d  = ^data_in;
`endif
        end else if (busy_q && half_tick) begin
            if (!phase) begin
                if (cur_bit) begin
                    line_d = ~line_q;
                end
            end else if (last_bit) begin
                state_d = IDLE;
                busy_d  = 1'b0;
`ifdef BEP_PARITY_EN
            end else if (bit_cnt_q == BIT_LAST) begin
                state_d = PARITY;
                line_d  = ~line_q;
`endif
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                shift_d   = shift_q >> 1;
                line_d    = ~line_q;
            end
        end
        idle_d = (state_d == IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            line_q    <= 1'b0;
            busy_q    <= 1'b0;
            idle_q    <= 1'b0;
`ifdef BEP_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            line_q    <= line_d;
            busy_q    <= busy_d;
            idle_q    <= idle_d;
`ifdef BEP_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule
